// File: rtl/pc_select_reg.sv
// pc_select_reg
//   Registered next-PC selector. Chooses among N_SRC prioritised redirect
//   sources (index 0 highest) or the sequential PC+STEP and owns the PC
//   register. Under stall the PC holds. One redirect request can be buffered
//   so that a request made during a stall is not lost.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   stall       in   hold the PC this cycle
//   src_valid   in   [N_SRC]        per-source redirect request
//   src_target  in   [N_SRC*WIDTH]  target of source i at [i*WIDTH +: WIDTH]
//   pc          out  [WIDTH]        current PC (registered)
//   redirect    out                 high for the cycle after pc was loaded
//                                   from a redirect target
//   pend_valid  out                 a buffered redirect is waiting
//   pend_idx    out  [IDX_W]        source index of the buffered redirect
module pc_select_reg #(
  parameter int unsigned      WIDTH    = 64,
  parameter int unsigned      N_SRC    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] STEP     = WIDTH'(4),
  localparam int unsigned     IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC*WIDTH-1:0] src_target,
  output logic [WIDTH-1:0]       pc,
  output logic                   redirect,
  output logic                   pend_valid,
  output logic [IDX_W-1:0]       pend_idx
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             redirect_q, redirect_d;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;

  logic             win_valid;
  logic [IDX_W-1:0] win_idx;
  logic [WIDTH-1:0] win_tgt;
  logic             take_new;

  // Lowest-index requester wins. A target is only read when its valid bit is
  // set, so unknown values on idle sources never reach the PC.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_tgt   = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (src_valid[i] && !win_valid) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(i);
        win_tgt   = src_target[i*WIDTH +: WIDTH];
      end
    end
  end

  // A new request displaces the buffered one when it is of equal or higher
  // priority; equal index means the newer request wins.
  assign take_new = win_valid && (win_idx <= pend_idx_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    pend_idx_d = pend_idx_q;
    pend_tgt_d = pend_tgt_q;
    unique case (state_q)
      IDLE: begin
        if (stall) begin
          if (win_valid) begin
            state_d    = PEND;
            pend_idx_d = win_idx;
            pend_tgt_d = win_tgt;
          end
        end else if (win_valid) begin
          pc_d       = win_tgt;
          redirect_d = 1'b1;
        end else begin
          pc_d = pc_q + STEP;
        end
      end
      PEND: begin
        if (stall) begin
          if (take_new) begin
            pend_idx_d = win_idx;
            pend_tgt_d = win_tgt;
          end
        end else begin
          pc_d       = take_new ? win_tgt : pend_tgt_q;
          redirect_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      pend_idx_q <= '0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      pend_idx_q <= pend_idx_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc         = pc_q;
  assign redirect   = redirect_q;
  assign pend_valid = (state_q == PEND);
  assign pend_idx   = pend_idx_q;

endmodule

// File: doc/pc_select_reg.md
# pc_select_reg

Parametrised, registered next-PC selector: the stateful successor to the two-way PC mux. Picks among `N_SRC` prioritised redirect sources or the sequential increment and owns the PC register. Holds the PC under a pipeline stall and buffers one pending redirect so a redirect arriving during a stall is never lost. Sits between the branch/exception logic and instruction fetch.

## Interface
- `WIDTH`, 64: PC width in bits.
- `N_SRC`, 4: number of redirect sources, ≥1; index 0 has highest priority.
- `RESET_PC`, 0: PC value loaded on reset.
- `STEP`, 4: sequential increment.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `stall`  in  1: hold the PC this cycle.
- `src_valid`  in  N_SRC: per-source redirect request.
- `src_target`  in  N_SRC*WIDTH: target of source i at bits `[i*WIDTH +: WIDTH]`.
- `pc`  out  WIDTH: current PC, registered.
- `redirect`  out  1: registered pulse; high for the cycle after `pc` was loaded from a redirect target.
- `pend_valid`  out  1: a buffered redirect is waiting.
- `pend_idx`  out  clog2(N_SRC) (min 1): source index of the buffered redirect.

## Operation
- Winner: the lowest index i with `src_valid[i]`=1 this cycle (`win_valid`, `win_idx`, `win_tgt`).
- States: IDLE (no pending) and PEND (pending register valid: `pend_idx`, `pend_tgt`).
- IDLE, `stall`=0:
  - `win_valid` → `pc` <= `win_tgt`, `redirect` <= 1.
  - Otherwise `pc` <= `pc`+`STEP`, `redirect` <= 0.
  - Stay in IDLE.
- IDLE, `stall`=1:
  - `pc` holds; `redirect` <= 0.
  - `win_valid` → capture `win_idx`/`win_tgt` and go to PEND.
- PEND, `stall`=1:
  - `pc` holds; `redirect` <= 0.
  - `win_valid` with `win_idx` ≤ `pend_idx` → overwrite the pending entry. An equal index means the newer request wins.
  - Otherwise keep the pending entry.
- PEND, `stall`=0:
  - `pc` <= `win_tgt` if `win_valid` and `win_idx` ≤ `pend_idx`; else `pc` <= `pend_tgt`.
  - `redirect` <= 1; go to IDLE.
- Arithmetic: `pc`+`STEP` truncated to `WIDTH` (wraps modulo 2^WIDTH). No carry out. Targets are used unmodified, with no alignment check.
- `src_valid`=0 ignores the corresponding `src_target` entirely (X-safe).
- Reset, asynchronous and at any time including mid-PEND:
  - `pc` = `RESET_PC`, `redirect` = 0, `pend_valid` = 0, `pend_idx` = 0.
  - The pending target is cleared to 0 and the state is IDLE.

## Timing
- All outputs come from flops; no combinational path from inputs to outputs.
- Redirect latency:
  - Request at edge n with `stall`=0 → new `pc` visible after edge n, with `redirect`=1 for that one cycle.
  - Under stall: `pc` updates on the first edge where `stall`=0.
- `pend_valid` rises after the edge that captured the request and falls after the edge that consumed it.
- Back-to-back redirects on consecutive unstalled cycles are each taken; `redirect` stays high both cycles.
- A stall of any length loses nothing: at most one pending entry, always the highest-priority (lowest-index) request seen, latest on ties.
- Deasserting `reset` takes effect synchronously to the next rising `clk`. The first active edge yields `pc`=`RESET_PC`+`STEP` if no request is present.

## Test plan
- **Reset then free-run.** `RESET_PC`=0x100, no requests, 3 edges → `pc` = 0x104, 0x108, 0x10C; `redirect`=0 throughout.
- **Priority.** `src_valid`=4'b0110, targets src1=0x2000 and src2=0x3000, `stall`=0 → `pc`=0x2000, `redirect`=1 for one cycle, then `pc`=0x2004.
- **Stalled redirect.**
  - `stall`=1 for 3 cycles; src3 → 0x4000 in the first cycle, then src1 → 0x5000 in the second.
  - Required: `pc` held throughout; `pend_idx`=3 and then 1.
  - On release, `pc`=0x5000 with `redirect`=1 and `pend_valid`=0.
- **Pending versus new request on release.** Pending src2 → 0x6000; on the release cycle src3 → 0x7000 is requested → `pc`=0x6000. Repeat with src0 → 0x8000 on release → `pc`=0x8000.
- **Wrap.** `WIDTH`=64, `pc`=0xFFFF_FFFF_FFFF_FFFC, no request → `pc`=0x0.
- **Reset mid-operation.** Assert `reset` asynchronously while in PEND → `pc`=`RESET_PC` and `pend_valid`=0 immediately, without waiting for an edge; after release the pending target is never taken.
